feature_out_reader: RTL and testbench

Streams finished MFCC feature vectors (cepstral coefficients plus their delta coefficients) out of the shared feature memory once the delta stage has completed. The block sits after the delta stage on the same 14-bit feature-memory port. It walks the memory frame by frame in the `{frame, column}` layout that the delta stage writes, and presents each 32-bit float word on a valid/ready output stream with back-pressure. It is the reader counterpart of the delta writer.

---
 rtl/feature_pkg.sv | 28 ++
 rtl/feat_fifo2.sv | 42 ++++
 rtl/feature_out_reader.sv | 140 ++++++++++++++
 tb/tb_feature_out_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_pkg.sv
// Shared types and constants for the feature-memory output reader.
// FEAT_OUT_DELTA_EN: when defined, each frame carries cepstra plus deltas
// (2*(cep_num+1) words); otherwise only the cepstra (cep_num+1 words).
package feature_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam int         FEAT_ADDR_WIDTH = 14;
    localparam logic [6:0] FRAME_FIRST     = 7'd2;
    localparam logic [7:0] FRAME_TAIL      = 8'd3;
    localparam logic [6:0] MIN_FRAMES      = 7'd5;

    // Index of the final column streamed for each frame.
    function automatic logic [6:0] last_col(input logic [6:0] cep);
`ifdef FEAT_OUT_DELTA_EN
        return (cep << 1) | 7'd1;
`else
        return cep;
`endif
    endfunction

endpackage

// File: rtl/feat_fifo2.sv
// Two-entry FIFO holding {last, data} words between the memory port and the
// output stream. Synchronous clear empties it and zeroes the storage so the
// head reads as zero after reset.
module feat_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;

    assign head = mem[rd_ptr];

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (clr) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/feature_out_reader.sv
// Streams finished feature vectors out of the shared feature memory, frame by
// frame in {frame, column} order, onto a valid/ready stream.
// FEAT_OUT_DELTA_EN selects whether delta columns follow the cepstra.
//
// state | meaning
// IDLE  | waiting for out_state_en
// CHECK | enough frames? load first address or finish at once
// READ  | issuing memory reads, paced by FIFO space
// DRAIN | last read issued; wait for memory and FIFO to empty
// DONE  | out_done high for this cycle
module feature_out_reader
    import feature_pkg::*;
#(
    parameter int ADDR_WIDTH = FEAT_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  out_state_en,
    input  logic [6:0]            frame_num,
    input  logic [6:0]            cep_num,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic                  mem_read_en,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [DATA_WIDTH-1:0] feat_data_out,
    output logic                  feat_valid,
    input  logic                  feat_ready,
    output logic                  feat_last,
    output logic                  out_done
);

    state_t     state;
    logic [6:0] frame_q;
    logic [6:0] col_q;
    logic [6:0] frame_num_q;
    logic [6:0] cep_num_q;
    logic       inflight;
    logic       inflight_last;

    logic [6:0] col_last;
    logic [7:0] frame_last;
    logic       col_wrap;
    logic       addr_last;
    logic       pop;
    logic [2:0] occupancy;
    logic [1:0] fifo_count;
    logic [DATA_WIDTH:0] fifo_head;

    // Frame bound kept in 8 bits so small frame counts cannot wrap.
    assign col_last   = last_col(cep_num_q);
    assign frame_last = {1'b0, frame_num_q} - FRAME_TAIL;
    assign col_wrap   = (col_q == col_last);
    assign addr_last  = ({1'b0, frame_q} == frame_last) && col_wrap;

    // Words committed = FIFO contents + the read in flight, less this
    // cycle's transfer; keep it under two so the FIFO never overflows.
    assign pop           = feat_valid && feat_ready;
    assign occupancy     = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
    assign mem_read_en   = (state == READ) && (occupancy < 3'd2);
    assign mem_read_addr = ADDR_WIDTH'({frame_q, col_q});

    assign feat_valid    = (fifo_count != 2'd0);
    assign feat_last     = fifo_head[DATA_WIDTH];
    assign feat_data_out = fifo_head[DATA_WIDTH-1:0];

    feat_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .clr       (rst),
        .push      (inflight),
        .pop       (pop),
        .push_data ({inflight_last, mem_data_in}),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Sequencing FSM, address counters and the read-in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            frame_q       <= '0;
            col_q         <= '0;
            frame_num_q   <= '0;
            cep_num_q     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            out_done      <= 1'b0;
        end else begin
            inflight      <= mem_read_en;
            inflight_last <= col_wrap;
            out_done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (out_state_en) begin
                        frame_num_q <= frame_num;
                        cep_num_q   <= cep_num;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (frame_num_q < MIN_FRAMES) begin
                        out_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        frame_q <= FRAME_FIRST;
                        col_q   <= '0;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (mem_read_en) begin
                        if (col_wrap) begin
                            col_q   <= '0;
                            frame_q <= frame_q + 7'd1;
                        end else begin
                            col_q <= col_q + 7'd1;
                        end
                        if (addr_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!inflight && fifo_count == 2'd0) begin
                        out_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feature_out_reader.sv
// Self-checking bench for feature_out_reader: table of stream configurations
// against a queue-based reference built from the frame/column rules, plus
// hand-written reset-mid-stream and busy-start sequences.
module tb_feature_out_reader;

    logic        clk;
    logic        rst;
    logic        out_state_en;
    logic [6:0]  frame_num;
    logic [6:0]  cep_num;
    logic [13:0] mem_read_addr;
    logic        mem_read_en;
    logic [31:0] mem_data_in;
    logic [31:0] feat_data_out;
    logic        feat_valid;
    logic        feat_ready;
    logic        feat_last;
    logic        out_done;

    feature_out_reader dut (
        .clk           (clk),
        .rst           (rst),
        .out_state_en  (out_state_en),
        .frame_num     (frame_num),
        .cep_num       (cep_num),
        .mem_read_addr (mem_read_addr),
        .mem_read_en   (mem_read_en),
        .mem_data_in   (mem_data_in),
        .feat_data_out (feat_data_out),
        .feat_valid    (feat_valid),
        .feat_ready    (feat_ready),
        .feat_last     (feat_last),
        .out_done      (out_done)
    );

`ifdef FEAT_OUT_DELTA_EN
    localparam int WM = 2;
`else
    localparam int WM = 1;
`endif

    typedef struct {
        int fn;
        int cep;
        int pct;
        bit busy;
        int exp_words;
        int exp_done;   // -1: not fixed (random ready)
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] mem [0:16383];
    logic [32:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int cur_pct = 100;
    bit mon_en = 0;
    int n_xfer;
    int n_reads;
    int first_read_rel;
    bit pv;
    bit pr;
    logic [32:0] pword;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: one-cycle read latency, garbage otherwise.
    always @(posedge clk) mem_data_in <= mem_read_en ? mem[mem_read_addr] : $urandom;

    initial begin
        feat_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            feat_ready = (int'($urandom_range(99)) < cur_pct);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream monitor: scoreboard, stall stability, read pacing.
    always @(negedge clk) begin
        int  rel;
        bit  p;
        logic [32:0] e;
        if (mon_en) begin
            rel = cyc - t0;
            p = feat_valid && feat_ready;
            if (pv && !pr) begin
                chk("stall_valid", feat_valid, 1);
                chk("stall_word", {feat_last, feat_data_out}, pword);
            end
            if (mem_read_en) begin
                chk("issue_rule", ((n_reads - n_xfer - int'(p)) < 2), 1);
                if (first_read_rel < 0) first_read_rel = rel;
                n_reads++;
            end
            if (p) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {feat_last, feat_data_out}, e);
                    if (cur_pct == 100) chk("xfer_cycle", rel, 4 + n_xfer);
                end
                n_xfer++;
            end
            pv = feat_valid;
            pr = feat_ready;
            pword = {feat_last, feat_data_out};
        end
    end

    task automatic start_stream(input int fn, input int cep, input int pct);
        int w;
        w = WM * (cep + 1);
        foreach (mem[i]) mem[i] = $urandom;
        exp_q.delete();
        for (int f = 2; f <= fn - 3; f++)
            for (int c = 0; c < w; c++)
                exp_q.push_back({(c == w - 1), mem[f * 128 + c]});
        cur_pct = pct;
        n_xfer = 0;
        n_reads = 0;
        first_read_rel = -1;
        pv = 0;
        pr = 0;
        @(posedge clk);
        #1;
        frame_num = 7'(fn);
        cep_num = 7'(cep);
        out_state_en = 1'b1;
        t0 = cyc;
        mon_en = 1;
        @(posedge clk);
        #1;
        out_state_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int done_rel;
        start_stream(v.fn, v.cep, v.pct);
        done_rel = -1;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (v.busy && (cyc - t0) == 6) begin
                out_state_en = 1'b1;
                frame_num = 7'd20;
            end else begin
                out_state_en = 1'b0;
            end
            if (out_done) begin
                done_rel = cyc - t0;
                break;
            end
        end
        if (done_rel < 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("word_count", n_xfer, v.exp_words);
            chk("words_left", exp_q.size(), 0);
            if (v.exp_done >= 0) chk("done_cycle", done_rel, v.exp_done);
            if (v.exp_words == 0) chk("no_reads", n_reads, 0);
            else chk("first_read_cycle", first_read_rel, 2);
            @(negedge clk);
            chk("done_pulse_width", out_done, 0);
        end
        mon_en = 0;
    endtask

    initial begin
        vecs[0] = '{8, 12, 100, 0, 4 * 13 * WM, 4 * 13 * WM + 5};
        vecs[1] = '{8, 12, 50, 0, 4 * 13 * WM, -1};
        vecs[2] = '{4, 12, 100, 0, 0, 2};
        vecs[3] = '{5, 0, 100, 0, WM, WM + 5};
        vecs[4] = '{6, 63, 70, 0, 2 * 64 * WM, -1};
        vecs[5] = '{0, 5, 100, 0, 0, 2};
        vecs[6] = '{6, 3, 100, 1, 2 * 4 * WM, 8 * WM + 5};
        vecs[7] = '{9, 7, 30, 0, 5 * 8 * WM, -1};

        rst = 1'b1;
        out_state_en = 1'b0;
        frame_num = '0;
        cep_num = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", mem_read_addr, 0);
        chk("rst_read_en", mem_read_en, 0);
        chk("rst_data", feat_data_out, 0);
        chk("rst_valid", feat_valid, 0);
        chk("rst_last", feat_last, 0);
        chk("rst_done", out_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of a stream, then restart from {2,0}.
        start_stream(8, 12, 100);
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            if (n_xfer >= 10) break;
        end
        chk("rst_mid_reached", (n_xfer >= 10), 1);
        #1;
        rst = 1'b1;
        mon_en = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_addr", mem_read_addr, 0);
        chk("mid_rst_read_en", mem_read_en, 0);
        chk("mid_rst_data", feat_data_out, 0);
        chk("mid_rst_valid", feat_valid, 0);
        chk("mid_rst_last", feat_last, 0);
        chk("mid_rst_done", out_done, 0);
        @(negedge clk);
        chk("mid_rst_valid_after", feat_valid, 0);
        chk("mid_rst_read_after", mem_read_en, 0);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
